// File: rtl/reg_port_scheduler_pkg.sv
// Shared types and widths for the register-port scheduler slice.
// Holds the debug FSM state encoding and the write-request bundle
// that the three write-port requesters are muxed through.
package reg_port_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ACCESS = 2'd1,
        D_ACK    = 2'd2
    } dbg_state_e;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wr_req_t;

endpackage : reg_port_scheduler_pkg

// File: rtl/reg_port_scheduler_scoreboard.sv
// reg_scoreboard: busy bits for registers with an outstanding MDU result
// plus the decode-stage hazard compare. Only instantiated when the
// REG_SCOREBOARD_EN build option is defined.
// x0 has no busy bit; a register whose MDU result is being written this
// cycle is treated as free because the register file forwards the write.
module reg_scoreboard
    import reg_port_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic                  i_rs1_used,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_rd_wen,
    output logic                  o_hazard_stall
);

    logic [31:1] r_busy;
    logic [31:1] w_set_vec;
    logic [31:1] w_clr_vec;
    logic [31:0] w_busy_eff;

    // Decode the set/clear addresses into one-hot vectors (bit 0 dropped).
    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        for (int i = 1; i < 32; i++) begin
            w_set_vec[i] = i_set_en && (i_set_addr == REG_ADDR_W'(i));
            w_clr_vec[i] = i_clr_en && (i_clr_addr == REG_ADDR_W'(i));
        end
    end

    // Busy bits: clear on the granted MDU write, set on issue; set wins on a tie.
    // NOTE: busy bits are ordinary flops, not a RAM, so they are reset and a reset empties the scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
        end
    end

    // Registers being written this cycle are not busy; x0 is never busy.
    assign w_busy_eff = {r_busy & ~w_clr_vec, 1'b0};

    assign o_hazard_stall = (i_rs1_used && w_busy_eff[i_rs1]) ||
                            (i_rs2_used && w_busy_eff[i_rs2]) ||
                            (i_rd_wen   && w_busy_eff[i_rd]);

endmodule : reg_scoreboard

// File: rtl/reg_port_scheduler.sv
// reg_port_scheduler: arbitrates the integer register file write port and
// read port 1 among pipeline writeback, the MDU and the debug module.
// Write priority is WB > MDU > debug. A starvation counter raises
// starve_stall when the MDU has waited STARVE_MAX cycles so the core
// freezes and lets the MDU in.
// Build option: define REG_SCOREBOARD_EN to add the MDU busy-bit
// scoreboard and hazard_stall; otherwise hazard_stall is tied low.
module reg_port_scheduler
    import reg_port_scheduler_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_stall_n,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    output logic        mdu_ready,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        id_rd_wen,
    output logic        hazard_stall,
    output logic        starve_stall,
    input  logic        dbg_halted,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  rf_raddr1,
    input  logic [31:0] rf_rdata1
);

    localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);

    dbg_state_e  r_dbg_state;
    logic        r_dbg_ack;
    logic [31:0] r_dbg_rdata;
    logic [3:0]  r_starve_cnt;

    logic        w_wb_grant;
    logic        w_mdu_grant;
    logic        w_dbg_active;
    logic        w_dbg_grant;
    wr_req_t     w_wr;

    // Fixed-priority write grant and write-port mux.
    always_comb begin
        w_wb_grant   = wb_wen && core_stall_n;
        w_mdu_grant  = !w_wb_grant && mdu_valid;
        w_dbg_active = (r_dbg_state == D_ACCESS) && dbg_req;
        w_dbg_grant  = !w_wb_grant && !mdu_valid && w_dbg_active && dbg_we;
        w_wr         = '0;
        if (w_wb_grant) begin
            w_wr = '{wen: 1'b1, waddr: wb_waddr, wdata: wb_wdata};
        end else if (w_mdu_grant) begin
            w_wr = '{wen: 1'b1, waddr: mdu_waddr, wdata: mdu_wdata};
        end else if (w_dbg_grant) begin
            w_wr = '{wen: 1'b1, waddr: dbg_addr, wdata: dbg_wdata};
        end
    end

    assign rf_wen    = w_wr.wen;
    assign rf_waddr  = w_wr.waddr;
    assign rf_wdata  = w_wr.wdata;
    assign mdu_ready = w_mdu_grant;
    assign rf_raddr1 = (r_dbg_state == D_ACCESS) ? dbg_addr : id_rs1;

    // Count consecutive MDU wait cycles; saturate so a core that ignores the stall cannot wrap it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (mdu_valid && !w_mdu_grant) begin
            if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Decoded straight from the counter flops, so it cannot glitch on input activity.
    assign starve_stall = (r_starve_cnt == STARVE_CNT);

    // Debug access FSM with registered ack and read data.
    // The access holds while any higher-priority writer owns the port so a debug write is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_state <= D_IDLE;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_dbg_state)
                D_IDLE: begin
                    if (dbg_req && dbg_halted && !r_dbg_ack) begin
                        r_dbg_state <= D_ACCESS;
                    end
                end
                D_ACCESS: begin
                    if (!dbg_req) begin
                        r_dbg_state <= D_IDLE;
                    end else if (!(mdu_valid || w_wb_grant)) begin
                        if (!dbg_we) begin
                            r_dbg_rdata <= rf_rdata1;
                        end
                        r_dbg_ack   <= 1'b1;
                        r_dbg_state <= D_ACK;
                    end
                end
                D_ACK: begin
                    if (!dbg_req) begin
                        r_dbg_ack   <= 1'b0;
                        r_dbg_state <= D_IDLE;
                    end
                end
                default: begin
                    r_dbg_ack   <= 1'b0;
                    r_dbg_state <= D_IDLE;
                end
            endcase
        end
    end

    assign dbg_ack   = r_dbg_ack;
    assign dbg_rdata = r_dbg_rdata;

`ifdef REG_SCOREBOARD_EN
    reg_scoreboard u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_set_en       (mdu_issue && core_stall_n),
        .i_set_addr     (mdu_issue_rd),
        .i_clr_en       (w_mdu_grant),
        .i_clr_addr     (mdu_waddr),
        .i_rs1          (id_rs1),
        .i_rs1_used     (id_rs1_used),
        .i_rs2          (id_rs2),
        .i_rs2_used     (id_rs2_used),
        .i_rd           (id_rd),
        .i_rd_wen       (id_rd_wen),
        .o_hazard_stall (hazard_stall)
    );
`else
    // Without a scoreboard the pipeline interlocks on mdu_ready itself.
    logic w_unused_sb;
    assign w_unused_sb  = ^{mdu_issue, mdu_issue_rd, id_rs2, id_rd,
                            id_rs1_used, id_rs2_used, id_rd_wen};
    assign hazard_stall = 1'b0;
`endif

endmodule : reg_port_scheduler

// File: tb/tb_reg_port_scheduler.sv
// Directed bench for reg_port_scheduler (STARVE_MAX = 4). A small
// register-file model closes the write/read loop. Scoreboard expectations
// follow the REG_SCOREBOARD_EN build option.
module tb_reg_port_scheduler;

`ifdef REG_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        core_stall_n;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_wen;
    logic        hazard_stall, starve_stall;
    logic        dbg_halted, dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;

    logic [31:0] rf_mem [32];
    int          n_checks;
    int          n_fail;

    reg_port_scheduler #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_stall_n (core_stall_n),
        .wb_wen       (wb_wen),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .mdu_valid    (mdu_valid),
        .mdu_waddr    (mdu_waddr),
        .mdu_wdata    (mdu_wdata),
        .mdu_ready    (mdu_ready),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd_wen    (id_rd_wen),
        .hazard_stall (hazard_stall),
        .starve_stall (starve_stall),
        .dbg_halted   (dbg_halted),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .dbg_rdata    (dbg_rdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_raddr1    (rf_raddr1),
        .rf_rdata1    (rf_rdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: x0 discards writes and reads as zero.
    always @(posedge clk) begin
        if (rf_wen && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
    end
    always_comb rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf_mem[rf_raddr1];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_stall_n = 1'b1;
        wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
        mdu_issue = 1'b0; mdu_issue_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_wen = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Full 4-phase debug access; exp_rdata is the value dbg_rdata must show at ack and after.
    task automatic dbg_access(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        settle();
        check({tag, " idle wen"}, rf_wen, 0);
        check({tag, " idle ack"}, dbg_ack, 0);
        next();
        settle();
        check({tag, " raddr1"}, rf_raddr1, addr);
        check({tag, " access wen"}, rf_wen, we);
        if (we) begin
            check({tag, " waddr"}, rf_waddr, addr);
            check({tag, " wdata"}, rf_wdata, wdata);
        end
        next();
        settle();
        check({tag, " ack"}, dbg_ack, 1);
        check({tag, " rdata"}, dbg_rdata, exp_rdata);
        check({tag, " ack wen"}, rf_wen, 0);
        dbg_req = 1'b0;
        next();
        settle();
        check({tag, " ack drop"}, dbg_ack, 0);
        check({tag, " rdata hold"}, dbg_rdata, exp_rdata);
        next();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        idle_inputs();
        dbg_halted = 1'b0;
        rst_n = 1'b0;

        // Reset state
        next();
        settle();
        check("reset rf_wen", rf_wen, 0);
        check("reset mdu_ready", mdu_ready, 0);
        check("reset dbg_ack", dbg_ack, 0);
        check("reset dbg_rdata", dbg_rdata, 0);
        check("reset hazard", hazard_stall, 0);
        check("reset starve", starve_stall, 0);
        next();
        rst_n = 1'b1;

        // WB/MDU conflict: WB owns the port for 3 cycles, then the MDU writes
        wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h0000_0055;
        mdu_valid = 1'b1; mdu_waddr = 5'd6; mdu_wdata = 32'h0000_0066;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("conflict wb waddr", rf_waddr, 5);
            check("conflict wb wen", rf_wen, 1);
            check("conflict mdu_ready", mdu_ready, 0);
            next();
        end
        wb_wen = 1'b0;
        settle();
        check("conflict mdu_ready after wb", mdu_ready, 1);
        check("conflict mdu waddr", rf_waddr, 6);
        check("conflict mdu wdata", rf_wdata, 32'h66);
        check("conflict starve below max", starve_stall, 0);
        next();
        mdu_valid = 1'b0;
        check("conflict x5 written", rf_mem[5], 32'h55);
        check("conflict x6 written", rf_mem[6], 32'h66);
        next();

        // Starvation: 4 wait cycles bring the counter to 4, then starve_stall
        wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h0000_0155;
        mdu_valid = 1'b1; mdu_waddr = 5'd9; mdu_wdata = 32'h0000_0099;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) begin
                settle();
                check("starve wait", starve_stall, 0);
                check("starve wait ready", mdu_ready, 0);
                next();
            end
            settle();
            check("starve asserted", starve_stall, 1);
            core_stall_n = 1'b0;
            #1;
            check("starve mdu_ready", mdu_ready, 1);
            check("starve mdu waddr", rf_waddr, 9);
            next();
            core_stall_n = 1'b1;
        end
        wb_wen = 1'b0; mdu_valid = 1'b0;
        settle();
        check("starve cleared", starve_stall, 0);
        next();

        // Scoreboard hazard on x7
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
        id_rs1 = 5'd7; id_rs1_used = 1'b1;
        settle();
        check("sb before busy", hazard_stall, 0);
        next();
        mdu_issue = 1'b0;
        settle();
        check("sb rs1 busy", hazard_stall, SB);
        next();
        id_rs1_used = 1'b0; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        settle();
        check("sb rs2 busy", hazard_stall, SB);
        next();
        id_rs2_used = 1'b0; id_rd = 5'd7; id_rd_wen = 1'b1;
        settle();
        check("sb rd busy", hazard_stall, SB);
        next();
        id_rd_wen = 1'b0; id_rs1_used = 1'b1;
        mdu_valid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'h0000_0077;
        settle();
        check("sb write-through ready", mdu_ready, 1);
        check("sb write-through hazard", hazard_stall, 0);
        next();
        mdu_valid = 1'b0;
        settle();
        check("sb cleared", hazard_stall, 0);
        next();
        mdu_issue = 1'b1; mdu_issue_rd = 5'd0; id_rs1 = 5'd0;
        next();
        mdu_issue = 1'b0;
        settle();
        check("sb x0 never busy", hazard_stall, 0);
        next();
        idle_inputs();

        // Debug round trip
        dbg_halted = 1'b1;
        dbg_access("dbg wr x3", 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0);
        check("dbg x3 in rf", rf_mem[3], 32'hDEAD_BEEF);
        dbg_access("dbg rd x3", 1'b0, 5'd3, 32'h0, 32'hDEAD_BEEF);
        dbg_access("dbg wr x0", 1'b1, 5'd0, 32'h1234_5678, 32'hDEAD_BEEF);
        dbg_access("dbg rd x0", 1'b0, 5'd0, 32'h0, 32'h0);

        // Debug vs MDU: MDU writes first, debug write follows one cycle later
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h0000_A5A5;
        next();
        mdu_valid = 1'b1; mdu_waddr = 5'd11; mdu_wdata = 32'h0000_B0B0;
        settle();
        check("dbgmdu mdu_ready", mdu_ready, 1);
        check("dbgmdu mdu waddr", rf_waddr, 11);
        next();
        mdu_valid = 1'b0;
        settle();
        check("dbgmdu held ack", dbg_ack, 0);
        check("dbgmdu dbg wen", rf_wen, 1);
        check("dbgmdu dbg waddr", rf_waddr, 10);
        check("dbgmdu dbg wdata", rf_wdata, 32'hA5A5);
        next();
        settle();
        check("dbgmdu ack", dbg_ack, 1);
        dbg_req = 1'b0;
        next();
        check("dbgmdu x10", rf_mem[10], 32'hA5A5);
        check("dbgmdu x11", rf_mem[11], 32'hB0B0);

        // Reset during D_ACCESS
        mdu_issue = 1'b1; mdu_issue_rd = 5'd12;
        next();
        mdu_issue = 1'b0; id_rs1 = 5'd12; id_rs1_used = 1'b1;
        settle();
        check("rst busy x12", hazard_stall, SB);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd13; dbg_wdata = 32'h0000_0013;
        next();
        settle();
        check("rst in access", rf_raddr1, 13);
        rst_n = 1'b0;
        #1;
        check("rst no write", rf_wen, 0);
        check("rst ack", dbg_ack, 0);
        check("rst fsm idle", rf_raddr1, 12);
        check("rst busy cleared", hazard_stall, 0);
        next();
        rst_n = 1'b1; dbg_req = 1'b0; id_rs1_used = 1'b0;
        settle();
        check("rst x13 untouched", rf_mem[13], 0);
        check("rst ack after", dbg_ack, 0);
        next();
        dbg_access("post-rst wr x13", 1'b1, 5'd13, 32'h0000_0077, 32'h0);
        check("post-rst x13", rf_mem[13], 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_port_scheduler
